// File: rtl/dct_pkg.sv
// rtl/dct_pkg.sv - shared constants and helpers for the DCT sample loader
// Purpose : default geometry of the DCT input stage, level-shift constant
//           and the block-slice offset helper used to address flat vectors.
// Ports   : none (package).
// Options : DCT_LEVEL_SHIFT_EN (consumed by dct_sample_loader).
package dct_pkg;

   localparam int DEF_DATA_W  = 8;
   localparam int DEF_N       = 8;
   localparam int DEF_IDX_W   = $clog2(DEF_N);
   localparam int LEVEL_SHIFT = 2 ** (DEF_DATA_W - 1);

   // Bit offset of sample k inside a flat N*w block vector.
   function automatic int slice_off(input int k, input int w);
      return k * w;
   endfunction

endpackage

// File: rtl/dct_sample_loader_if.sv
// rtl/dct_sample_loader_if.sv - sample-in / block-out handshake bundle
// Purpose : groups the sample stream and the parallel block stream.
// Signals : in_valid/in_ready/in_data  - one sample per accepted cycle
//           blk_valid/blk_ready/blk_data/blk_last_bank - one N-sample block
// Modports: master - environment side (drives samples, consumes blocks)
//           slave  - loader side
interface dct_sample_loader_if
   import dct_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int N      = DEF_N
);

   logic                in_valid;
   logic                in_ready;
   logic [DATA_W-1:0]   in_data;
   logic                blk_valid;
   logic                blk_ready;
   logic [N*DATA_W-1:0] blk_data;
   logic                blk_last_bank;

   modport master (
      output in_valid, in_data, blk_ready,
      input  in_ready, blk_valid, blk_data, blk_last_bank
   );

   modport slave (
      input  in_valid, in_data, blk_ready,
      output in_ready, blk_valid, blk_data, blk_last_bank
   );

endinterface

// File: rtl/dct_sample_bank.sv
// rtl/dct_sample_bank.sv - one N-entry sample register bank
// Purpose : holds one DCT block; single indexed write port, flat read vector.
// Ports   : clk, reset (async active-low)
//           we, widx, wdata - write sample wdata into entry widx when we=1
//           rdata           - all N entries, entry k at [k*DATA_W +: DATA_W]
module dct_sample_bank
   import dct_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int N      = DEF_N
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     we,
   input  logic [$clog2(N)-1:0]     widx,
   input  logic [DATA_W-1:0]        wdata,
   output logic [N*DATA_W-1:0]      rdata
);

   localparam int IDX_W = $clog2(N);

   logic [N*DATA_W-1:0] mem;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem <= '0;
      end else if (we) begin
         for (int k = 0; k < N; k++) begin
            if (widx == IDX_W'(k)) begin
               mem[slice_off(k, DATA_W) +: DATA_W] <= wdata;
            end
         end
      end
   end

   assign rdata = mem;

endmodule

// File: rtl/dct_sample_loader.sv
// rtl/dct_sample_loader.sv - ping-pong sample-to-block loader for the 1D DCT
// Purpose : collects samples one per cycle into N-sample blocks using two
//           banks; one fills while the other is offered downstream.
// Ports   : clk, reset (async active-low)
//           bus (dct_sample_loader_if.slave):
//             in_valid/in_ready/in_data    - sample stream in
//             blk_valid/blk_ready/blk_data - block stream out
//             blk_last_bank                - bank driving blk_data
// Options : DCT_LEVEL_SHIFT_EN - store samples as in_data - 2^(DATA_W-1)
//           (MSB inverted, two's complement); undefined stores raw samples.
module dct_sample_loader
   import dct_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int N      = DEF_N
) (
   input  logic                clk,
   input  logic                reset,
   dct_sample_loader_if.slave  bus
);

   localparam int                IDX_W    = $clog2(N);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N - 1);

   logic                wr_bank;
   logic                rd_bank;
   logic [IDX_W-1:0]    wr_idx;
   logic [1:0]          full;
   logic [1:0]          full_next;

   logic                accept;
   logic                xfer;
   logic                block_done;
   logic [DATA_W-1:0]   store_data;
   logic [N*DATA_W-1:0] rdata0;
   logic [N*DATA_W-1:0] rdata1;

   // Ready comes only from registered state, so a bank freed this cycle
   // becomes writable on the following cycle.
   assign bus.in_ready      = !full[wr_bank];
   assign bus.blk_valid     = full[rd_bank];
   assign bus.blk_data      = rd_bank ? rdata1 : rdata0;
   assign bus.blk_last_bank = rd_bank;

   assign accept     = bus.in_valid && bus.in_ready;
   assign xfer       = bus.blk_valid && bus.blk_ready;
   assign block_done = accept && (wr_idx == LAST_IDX);

`ifdef DCT_LEVEL_SHIFT_EN
   // Subtracting 2^(DATA_W-1) from an unsigned sample is an MSB flip.
   assign store_data = {~bus.in_data[DATA_W-1], bus.in_data[DATA_W-2:0]};
`else
   assign store_data = bus.in_data;
`endif

   dct_sample_bank #(.DATA_W(DATA_W), .N(N)) u_bank0 (
      .clk   (clk),
      .reset (reset),
      .we    (accept && !wr_bank),
      .widx  (wr_idx),
      .wdata (store_data),
      .rdata (rdata0)
   );

   dct_sample_bank #(.DATA_W(DATA_W), .N(N)) u_bank1 (
      .clk   (clk),
      .reset (reset),
      .we    (accept && wr_bank),
      .widx  (wr_idx),
      .wdata (store_data),
      .rdata (rdata1)
   );

   // A transfer and a block completion never hit the same bank: accept needs
   // the write bank empty, transfer needs the read bank full.
   always_comb begin
      full_next = full;
      if (xfer) begin
         full_next[rd_bank] = 1'b0;
      end
      if (block_done) begin
         full_next[wr_bank] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_bank <= 1'b0;
         rd_bank <= 1'b0;
         wr_idx  <= '0;
         full    <= 2'b00;
      end else begin
         full <= full_next;
         if (accept) begin
            if (block_done) begin
               wr_idx  <= '0;
               wr_bank <= ~wr_bank;
            end else begin
               wr_idx <= wr_idx + 1'b1;
            end
         end
         if (xfer) begin
            rd_bank <= ~rd_bank;
         end
      end
   end

endmodule

// File: tb/tb_dct_sample_loader.sv
// tb/tb_dct_sample_loader.sv - self-checking bench for dct_sample_loader
// Purpose : table-driven first-block vectors, directed multi-cycle sequences
//           and a randomised stream checked by an in-order block scoreboard.
// Options : DCT_LEVEL_SHIFT_EN selects the level-shifted expectations.
module tb_dct_sample_loader;
   import dct_pkg::*;

   localparam int DW = 8;
   localparam int NS = 8;

   logic clk = 1'b0;
   logic reset = 1'b1;

   always #5 clk = ~clk;

   dct_sample_loader_if #(.DATA_W(DW), .N(NS)) bus ();

   dct_sample_loader #(.DATA_W(DW), .N(NS)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int vecs = 0;
   int errs = 0;
   int stalls = 0;

   logic [7:0]  exp_q[$];
   logic [63:0] got_blk[$];
   logic        got_bank[$];
   int          acc = 0;
   int          acc_blocks = 0;
   int          xfers = 0;
   logic        hold_pending = 1'b0;
   logic [63:0] held = '0;
   logic        rnd_done = 1'b0;

   typedef struct {
      logic        iv;
      logic [7:0]  id;
      logic        br;
      logic        ir;
      logic        bv;
      logic        bk;
      logic        cd;
      logic [63:0] bd;
   } vec_t;

   vec_t tab[10];

   function automatic logic [7:0] shift8(input logic [7:0] x);
`ifdef DCT_LEVEL_SHIFT_EN
      return x ^ 8'h80;
`else
      return x;
`endif
   endfunction

   function automatic logic [63:0] shift64(input logic [63:0] x);
`ifdef DCT_LEVEL_SHIFT_EN
      return x ^ {8{8'h80}};
`else
      return x;
`endif
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard: expected outputs follow from counts of accepted blocks and
   // transfers, and each transferred block must equal the next N samples.
   always @(negedge clk) begin
      int outst;
      logic [63:0] expv;
      if (reset) begin
         outst = acc_blocks - xfers;
         chk("mon_in_ready", bus.in_ready, outst < 2);
         chk("mon_blk_valid", bus.blk_valid, outst > 0);
         if (hold_pending) chk("mon_blk_hold", bus.blk_data, held);
         if (bus.blk_valid && bus.blk_ready) begin
            expv = '0;
            for (int k = 0; k < NS; k++) begin
               if (exp_q.size() > 0) expv[k*8 +: 8] = exp_q.pop_front();
            end
            chk("mon_blk_data", bus.blk_data, expv);
            chk("mon_blk_bank", bus.blk_last_bank, xfers % 2);
            got_blk.push_back(bus.blk_data);
            got_bank.push_back(bus.blk_last_bank);
            xfers++;
         end
         hold_pending = bus.blk_valid && !bus.blk_ready;
         held = bus.blk_data;
         if (bus.in_valid && bus.in_ready) begin
            exp_q.push_back(shift8(bus.in_data));
            acc++;
            if (acc % NS == 0) acc_blocks++;
         end
      end
   end

   // Asserts reset off-edge, checks outputs clear immediately, releases it.
   task automatic do_reset();
      reset = 1'b0;
      exp_q.delete();
      got_blk.delete();
      got_bank.delete();
      acc = 0;
      acc_blocks = 0;
      xfers = 0;
      hold_pending = 1'b0;
      stalls = 0;
      #1;
      chk("rst_in_ready", bus.in_ready, 1'b1);
      chk("rst_blk_valid", bus.blk_valid, 1'b0);
      chk("rst_blk_data", bus.blk_data, 64'h0);
      chk("rst_blk_bank", bus.blk_last_bank, 1'b0);
      @(posedge clk);
      #3 reset = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] x);
      logic got;
      int guard;
      guard = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = x;
      while (1) begin
         @(negedge clk);
         got = bus.in_ready;
         @(posedge clk);
         #1;
         if (got) break;
         stalls++;
         guard++;
         if (guard > 300) begin
            chk("send_timeout", 64'(guard), 64'd0);
            break;
         end
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      bus.in_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int guard;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.blk_ready = 1'b0;

      for (int i = 0; i < 10; i++) begin
         tab[i].iv = (i < 8);
         tab[i].id = (i < 8) ? 8'(10 + i) : 8'hEE;
         tab[i].br = 1'b1;
         tab[i].ir = 1'b1;
         tab[i].bv = (i == 8);
         tab[i].bk = (i == 9);
         tab[i].cd = (i == 8);
         tab[i].bd = shift64(64'h1110_0F0E_0D0C_0B0A);
      end

      #1;
      do_reset();

      // First block: valid the cycle after the 8th accept, one-cycle pulse.
      for (int i = 0; i < 10; i++) begin
         bus.in_valid  = tab[i].iv;
         bus.in_data   = tab[i].id;
         bus.blk_ready = tab[i].br;
         #1;
         chk($sformatf("t1_in_ready[%0d]", i), bus.in_ready, tab[i].ir);
         chk($sformatf("t1_blk_valid[%0d]", i), bus.blk_valid, tab[i].bv);
         chk($sformatf("t1_blk_bank[%0d]", i), bus.blk_last_bank, tab[i].bk);
         if (tab[i].cd) chk($sformatf("t1_blk_data[%0d]", i), bus.blk_data, tab[i].bd);
         @(posedge clk);
         #1;
      end

      // 24 back-to-back samples: no stalls, banks 0,1,0.
      do_reset();
      bus.blk_ready = 1'b1;
      for (int i = 0; i < 24; i++) send(8'(i));
      idle(3);
      chk("t2_stalls", 64'(stalls), 64'd0);
      chk("t2_blocks", 64'(got_blk.size()), 64'd3);
      if (got_blk.size() == 3) begin
         chk("t2_blk0", got_blk[0], shift64(64'h0706_0504_0302_0100));
         chk("t2_blk1", got_blk[1], shift64(64'h0F0E_0D0C_0B0A_0908));
         chk("t2_blk2", got_blk[2], shift64(64'h1716_1514_1312_1110));
         chk("t2_bank0", got_bank[0], 1'b0);
         chk("t2_bank1", got_bank[1], 1'b1);
         chk("t2_bank2", got_bank[2], 1'b0);
      end

      // Backpressure: both banks fill, then single-cycle releases.
      do_reset();
      bus.blk_ready = 1'b0;
      for (int i = 0; i < 16; i++) send(8'(i));
      #1;
      chk("t3_full_in_ready", bus.in_ready, 1'b0);
      chk("t3_full_valid", bus.blk_valid, 1'b1);
      chk("t3_full_data", bus.blk_data, shift64(64'h0706_0504_0302_0100));
      chk("t3_full_bank", bus.blk_last_bank, 1'b0);
      bus.blk_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.blk_ready = 1'b0;
      #1;
      chk("t3_after1_in_ready", bus.in_ready, 1'b1);
      chk("t3_after1_valid", bus.blk_valid, 1'b1);
      chk("t3_after1_data", bus.blk_data, shift64(64'h0F0E_0D0C_0B0A_0908));
      chk("t3_after1_bank", bus.blk_last_bank, 1'b1);
      bus.blk_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.blk_ready = 1'b0;
      #1;
      chk("t3_after2_valid", bus.blk_valid, 1'b0);
      chk("t3_after2_bank", bus.blk_last_bank, 1'b0);

      // Async reset mid-block discards the partial block.
      do_reset();
      bus.blk_ready = 1'b1;
      for (int i = 0; i < 5; i++) send(8'(50 + i));
      #2;
      do_reset();
      for (int i = 0; i < 8; i++) send(8'(100 + i));
      idle(3);
      chk("t4_blocks", 64'(got_blk.size()), 64'd1);
      if (got_blk.size() > 0) begin
         chk("t4_blk0", got_blk[0], shift64(64'h6B6A_6968_6766_6564));
         chk("t4_bank0", got_bank[0], 1'b0);
      end

      // Level-shift pattern.
      do_reset();
      bus.blk_ready = 1'b0;
      send(8'd0);   send(8'd128); send(8'd255); send(8'd1);
      send(8'd127); send(8'd129); send(8'd64);  send(8'd192);
      #1;
      chk("t5_valid", bus.blk_valid, 1'b1);
`ifdef DCT_LEVEL_SHIFT_EN
      chk("t5_data", bus.blk_data, 64'h40C0_01FF_817F_0080);
`else
      chk("t5_data", bus.blk_data, 64'hC040_817F_01FF_8000);
`endif
      bus.blk_ready = 1'b1;
      idle(2);

      // Random valid/ready over 1000 samples.
      do_reset();
      rnd_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 1000; i++) begin
               if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
               send(8'(i * 7 + 3));
            end
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               bus.blk_ready = 1'($urandom_range(0, 1));
               @(posedge clk);
               #1;
            end
         end
      join
      bus.blk_ready = 1'b1;
      guard = 0;
      while ((exp_q.size() != 0 || bus.blk_valid) && guard < 40) begin
         idle(1);
         guard++;
      end
      chk("t6_drained", 64'(exp_q.size()), 64'd0);
      chk("t6_accepts", 64'(acc), 64'd1000);
      chk("t6_blocks", 64'(xfers), 64'd125);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
